// File: rtl/spmv_multi_fifo.sv
// Bank of NUM_CH independent first-word-fall-through FIFOs with per-channel
// fill level, threshold flags, sticky overflow and high-water mark.
module spmv_multi_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4,
    parameter int LOW_THER   = 1,
    parameter int HIGH_THER  = 12,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         err_clr,
    input  logic [NUM_CH-1:0]            wr_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_CH-1:0]            wr_ready,
    output logic [NUM_CH-1:0]            rd_valid,
    output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_CH-1:0]            rd_ready,
    output logic [NUM_CH*(AW+1)-1:0]     fill_level,
    output logic [NUM_CH-1:0]            need_data,
    output logic [NUM_CH-1:0]            no_need_data,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH*(AW+1)-1:0]     max_level
);

    localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];
    localparam logic [AW:0] ZERO_P  = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_P   = {{AW{1'b0}}, 1'b1};
    localparam logic [31:0] LOW_P   = LOW_THER[31:0];
    localparam logic [31:0] HIGH_P  = HIGH_THER[31:0];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_r [DEPTH];
        logic [AW:0]           wr_ptr_r;
        logic [AW:0]           rd_ptr_r;
        logic [AW:0]           max_r;
        logic                  ovf_r;
        logic [AW:0]           fill_s;
        logic                  wr_rdy_s;
        logic                  rd_vld_s;
        logic                  wr_en_s;
        logic                  rd_en_s;
        logic                  ovf_set_s;

        // Handshake decode; flush suppresses any transfer in its cycle.
        always_comb begin
            fill_s    = wr_ptr_r - rd_ptr_r;
            wr_rdy_s  = (fill_s != DEPTH_P);
            rd_vld_s  = (fill_s != ZERO_P);
            wr_en_s   = wr_valid[c] & wr_rdy_s & ~flush;
            rd_en_s   = rd_ready[c] & rd_vld_s & ~flush;
            ovf_set_s = wr_valid[c] & ~wr_rdy_s;
        end

        // Pointer update; flush dominates same-cycle writes and pops.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_r <= ZERO_P;
                rd_ptr_r <= ZERO_P;
            end else if (flush) begin
                wr_ptr_r <= ZERO_P;
                rd_ptr_r <= ZERO_P;
            end else begin
                if (wr_en_s) wr_ptr_r <= wr_ptr_r + ONE_P;
                if (rd_en_s) rd_ptr_r <= rd_ptr_r + ONE_P;
            end
        end

        // Sticky overflow (set beats clear) and high-water mark tracking.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_r <= 1'b0;
                max_r <= ZERO_P;
            end else begin
                if (ovf_set_s)    ovf_r <= 1'b1;
                else if (err_clr) ovf_r <= 1'b0;
                if (err_clr)             max_r <= fill_s;
                else if (fill_s > max_r) max_r <= fill_s;
            end
        end

        // Storage write; the array carries no reset.
        always_ff @(posedge clk) begin
            if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data[c*DATA_WIDTH +: DATA_WIDTH];
        end

        assign wr_ready[c]                          = wr_rdy_s;
        assign rd_valid[c]                          = rd_vld_s;
        assign rd_data[c*DATA_WIDTH +: DATA_WIDTH]  = mem_r[rd_ptr_r[AW-1:0]];
        assign fill_level[c*(AW+1) +: (AW+1)]       = fill_s;
        assign max_level[c*(AW+1) +: (AW+1)]        = max_r;
        assign overflow[c]                          = ovf_r;
        assign need_data[c]                         = (32'(fill_s) < LOW_P);
        assign no_need_data[c]                      = (32'(fill_s) > HIGH_P);
    end

endmodule
